stream_gen: RTL and testbench

//  Test-traffic source driven by the AXI4-Lite control block: consumes its

---
 rtl/stream_gen.sv | 113 +++++++++++
 tb/tb_stream_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_gen.sv
// AXI4-Stream test-traffic source: on an accepted start it emits cycle_count beats whose
// 32-bit lanes all carry the beat index, and reports busy/done plus beat and clock counters.
module stream_gen #(
    parameter int DW = 512
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [31:0]   cycle_count,
    input  logic          start,
    output logic [DW-1:0] axis_out_tdata,
    output logic          axis_out_tvalid,
    output logic          axis_out_tlast,
    input  logic          axis_out_tready,
    output logic          busy,
    output logic          done,
    output logic [31:0]   beats_sent,
    output logic [31:0]   elapsed
);

    localparam int LANES = DW / 32;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   index_q, index_d, index_inc;
    logic [DW-1:0] tdata_d;
    logic          tvalid_d, tlast_d, busy_d, done_d;
    logic [31:0]   beats_d, elapsed_d;
    logic          handshake;

    // A beat transfers when tvalid and tready are both high at a rising edge; once tvalid
    // is raised, tdata/tlast/tvalid stay frozen until that transfer happens.
    assign handshake = axis_out_tvalid && axis_out_tready;
    assign index_inc = index_q + 32'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= IDLE;
            count_q         <= '0;
            index_q         <= '0;
            axis_out_tdata  <= '0;
            axis_out_tvalid <= 1'b0;
            axis_out_tlast  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            beats_sent      <= '0;
            elapsed         <= '0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            index_q         <= index_d;
            axis_out_tdata  <= tdata_d;
            axis_out_tvalid <= tvalid_d;
            axis_out_tlast  <= tlast_d;
            busy            <= busy_d;
            done            <= done_d;
            beats_sent      <= beats_d;
            elapsed         <= elapsed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        tdata_d   = axis_out_tdata;
        tvalid_d  = axis_out_tvalid;
        tlast_d   = axis_out_tlast;
        busy_d    = busy;
        done_d    = 1'b0;
        beats_d   = beats_sent;
        elapsed_d = elapsed;
        case (state_q)
            IDLE: begin
                if (start) begin
                    beats_d   = '0;
                    elapsed_d = '0;
                    if (cycle_count != 32'd0) begin
                        count_d  = cycle_count;
                        index_d  = '0;
                        tdata_d  = '0;
                        tvalid_d = 1'b1;
                        tlast_d  = (cycle_count == 32'd1);
                        busy_d   = 1'b1;
                        state_d  = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (elapsed != 32'hFFFF_FFFF) elapsed_d = elapsed + 32'd1;
                if (handshake) begin
                    beats_d = beats_sent + 32'd1;
                    if (axis_out_tlast) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        index_d = index_inc;
                        tdata_d = {LANES{index_inc}};
                        tlast_d = (index_inc == count_q - 32'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stream_gen.sv
// Directed bench for stream_gen: a DW=512 instance for most scenarios and a DW=32
// instance for the back-to-back restart scenario.
module tb_stream_gen;

    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   cycle_count = '0;
    logic          start = 1'b0;
    logic [DW-1:0] tdata;
    logic          tvalid, tlast;
    logic          tready = 1'b0;
    logic          busy, done;
    logic [31:0]   beats_sent, elapsed;

    logic [31:0]   n_count = '0;
    logic          n_start = 1'b0;
    logic [31:0]   n_tdata;
    logic          n_tvalid, n_tlast;
    logic          n_tready = 1'b0;
    logic          n_busy, n_done;
    logic [31:0]   n_beats, n_elapsed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_gen #(.DW(DW)) u_dut (
        .clk(clk), .resetn(resetn), .cycle_count(cycle_count), .start(start),
        .axis_out_tdata(tdata), .axis_out_tvalid(tvalid), .axis_out_tlast(tlast),
        .axis_out_tready(tready), .busy(busy), .done(done),
        .beats_sent(beats_sent), .elapsed(elapsed)
    );

    stream_gen #(.DW(32)) u_narrow (
        .clk(clk), .resetn(resetn), .cycle_count(n_count), .start(n_start),
        .axis_out_tdata(n_tdata), .axis_out_tvalid(n_tvalid), .axis_out_tlast(n_tlast),
        .axis_out_tready(n_tready), .busy(n_busy), .done(n_done),
        .beats_sent(n_beats), .elapsed(n_elapsed)
    );

    function automatic logic [DW-1:0] pat(input logic [31:0] i);
        return {(DW/32){i}};
    endfunction

    // Advance one edge and land 1 time unit after it for sampling and driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if ({tvalid, tlast, busy, done} !== 4'b0000 || tdata !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got v%b l%b b%b d%b data %0h exp all 0", tvalid, tlast, busy, done, tdata);
        end
        checks++;
        if (beats_sent !== 32'd0 || elapsed !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats got beats %0d elapsed %0d exp 0 0", beats_sent, elapsed);
        end
        checks++;
        if ({n_tvalid, n_busy, n_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_narrow got v%b b%b d%b exp 000", n_tvalid, n_busy, n_done);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        start = 1'b1; cycle_count = 32'd4; tready = 1'b1;
        tick();
        start = 1'b0; cycle_count = 32'd99;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tvalid !== 1'b1 || busy !== 1'b1 || tdata !== pat(i) || tlast !== (i == 3)) begin
                errors++;
                $display("FAIL basic_beat%0d got v%b b%b l%b data %0h exp v1 b1 l%b lane %0d", i, tvalid, busy, tlast, tdata[31:0], (i == 3), i);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tvalid !== 1'b0 || tlast !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got d%b b%b v%b l%b exp d1 b0 v0 l0", done, busy, tvalid, tlast);
        end
        checks++;
        if (beats_sent !== 32'd4 || elapsed !== 32'd4) begin
            errors++;
            $display("FAIL basic_stats got beats %0d elapsed %0d exp 4 4", beats_sent, elapsed);
        end
        tick();
        checks++;
        if (done !== 1'b0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got d%b v%b exp d0 v0", done, tvalid);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] rdy;
        int idx;
        rdy = 5'b10101;
        idx = 0;
        start = 1'b1; cycle_count = 32'd3; tready = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tready = rdy[k];
            checks++;
            if (tvalid !== 1'b1 || tdata !== pat(idx) || tlast !== (idx == 2) || done !== 1'b0) begin
                errors++;
                $display("FAIL bp_cycle%0d got v%b l%b d%b lane %0d exp v1 l%b d0 lane %0d", k, tvalid, tlast, done, tdata[31:0], (idx == 2), idx);
            end
            tick();
            if (rdy[k]) idx++;
        end
        tready = 1'b1;
        checks++;
        if (done !== 1'b1 || tvalid !== 1'b0 || beats_sent !== 32'd3 || elapsed !== 32'd5) begin
            errors++;
            $display("FAIL bp_end got d%b v%b beats %0d elapsed %0d exp d1 v0 3 5", done, tvalid, beats_sent, elapsed);
        end
        tick();
    endtask

    task automatic test_zero_count();
        start = 1'b1; cycle_count = 32'd0;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got d%b v%b b%b exp d1 v0 b0", done, tvalid, busy);
        end
        checks++;
        if (beats_sent !== 32'd0 || elapsed !== 32'd0) begin
            errors++;
            $display("FAIL zero_stats got beats %0d elapsed %0d exp 0 0", beats_sent, elapsed);
        end
        tick();
        checks++;
        if (done !== 1'b0 || tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_after got d%b v%b b%b exp d0 v0 b0", done, tvalid, busy);
        end
    endtask

    task automatic test_ignore_start();
        start = 1'b1; cycle_count = 32'd8; tready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start = (i == 3);
            cycle_count = (i == 3) ? 32'd2 : 32'd8;
            checks++;
            if (tvalid !== 1'b1 || tdata !== pat(i) || tlast !== (i == 7)) begin
                errors++;
                $display("FAIL ign_beat%0d got v%b l%b lane %0d exp v1 l%b lane %0d", i, tvalid, tlast, tdata[31:0], (i == 7), i);
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || beats_sent !== 32'd8 || elapsed !== 32'd8) begin
            errors++;
            $display("FAIL ign_end got d%b beats %0d elapsed %0d exp d1 8 8", done, beats_sent, elapsed);
        end
        tick();
        checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_idle got v%b b%b exp v0 b0", tvalid, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; cycle_count = 32'd100; tready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        checks++;
        if (tvalid !== 1'b1 || tdata !== pat(50) || beats_sent !== 32'd50) begin
            errors++;
            $display("FAIL rst_beat50 got v%b lane %0d beats %0d exp v1 50 50", tvalid, tdata[31:0], beats_sent);
        end
        resetn = 1'b0;
        tick();
        checks++;
        if ({tvalid, busy, done, tlast} !== 4'b0000 || beats_sent !== 32'd0 || elapsed !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid got v%b b%b d%b l%b beats %0d elapsed %0d exp all 0", tvalid, busy, done, tlast, beats_sent, elapsed);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_nodone got d%b v%b exp d0 v0", done, tvalid);
        end
        start = 1'b1; cycle_count = 32'd1;
        tick();
        start = 1'b0;
        checks++;
        if (tvalid !== 1'b1 || tlast !== 1'b1 || tdata !== pat(0)) begin
            errors++;
            $display("FAIL rst_single got v%b l%b lane %0d exp v1 l1 lane 0", tvalid, tlast, tdata[31:0]);
        end
        tick();
        checks++;
        if (done !== 1'b1 || beats_sent !== 32'd1 || elapsed !== 32'd1) begin
            errors++;
            $display("FAIL rst_single_end got d%b beats %0d elapsed %0d exp d1 1 1", done, beats_sent, elapsed);
        end
        tick();
    endtask

    task automatic test_max_count();
        start = 1'b1; cycle_count = 32'hFFFF_FFFF; tready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tvalid !== 1'b1 || tlast !== 1'b0 || tdata !== pat(i)) begin
                errors++;
                $display("FAIL max_beat%0d got v%b l%b lane %0d exp v1 l0 lane %0d", i, tvalid, tlast, tdata[31:0], i);
            end
            tick();
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        n_start = 1'b1; n_count = 32'd1; n_tready = 1'b1;
        tick();
        n_start = 1'b0;
        checks++;
        if (n_tvalid !== 1'b1 || n_tlast !== 1'b1 || n_tdata !== 32'd0) begin
            errors++;
            $display("FAIL b2b_first got v%b l%b data %0h exp v1 l1 0", n_tvalid, n_tlast, n_tdata);
        end
        tick();
        checks++;
        if (n_done !== 1'b1 || n_beats !== 32'd1) begin
            errors++;
            $display("FAIL b2b_done1 got d%b beats %0d exp d1 1", n_done, n_beats);
        end
        n_start = 1'b1; n_count = 32'd2;
        tick();
        n_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (n_tvalid !== 1'b1 || n_busy !== 1'b1 || n_done !== 1'b0 || n_tdata !== i || n_tlast !== (i == 1)) begin
                errors++;
                $display("FAIL b2b_beat%0d got v%b b%b d%b l%b data %0h exp v1 b1 d0 l%b %0h", i, n_tvalid, n_busy, n_done, n_tlast, n_tdata, (i == 1), i);
            end
            tick();
        end
        checks++;
        if (n_done !== 1'b1 || n_tvalid !== 1'b0 || n_beats !== 32'd2 || n_elapsed !== 32'd2) begin
            errors++;
            $display("FAIL b2b_end got d%b v%b beats %0d elapsed %0d exp d1 v0 2 2", n_done, n_tvalid, n_beats, n_elapsed);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_ignore_start();
        test_reset_mid_run();
        test_max_count();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
